// File: rtl/jtag_dbg_bridge.sv
// jtag_dbg_bridge: core-domain executor of JTAG debug ops (register strobe + one bus transfer), halt and reset conditioning.
// Optional bus-grant timeout with sticky err_o when JTAG_BRIDGE_TIMEOUT_EN is defined.
module jtag_dbg_bridge #(
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dbg_op_req_i,
    input  logic        dbg_reg_we_i,
    input  logic [4:0]  dbg_reg_addr_i,
    input  logic [31:0] dbg_reg_wdata_i,
    input  logic        dbg_mem_we_i,
    input  logic [31:0] dbg_mem_addr_i,
    input  logic [31:0] dbg_mem_wdata_i,
    input  logic        dbg_halt_req_i,
    input  logic        dbg_reset_req_i,
    output logic [31:0] dbg_reg_rdata_o,
    output logic [31:0] dbg_mem_rdata_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_addr_o,
    output logic [31:0] reg_wdata_o,
    input  logic [31:0] reg_rdata_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic [31:0] bus_rdata_i,
    output logic        core_halt_o,
    output logic        core_rst_req_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam int RW = $clog2(RST_CYCLES + 1);

    if (RST_CYCLES < 1) begin : g_bad_rst
        $error("RST_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_to
        $error("TIMEOUT_CYCLES must fit the 8-bit counter (1..255)");
    end

    typedef enum logic [1:0] {IDLE, CAPT, BUS, DONE} state_e;

    state_e        state_q, state_d;
    logic          s1_q, s2_q, s3_q, start_q;
    logic          pend_q, pend_d;
    logic          reg_we_q, mem_we_q;
    logic [4:0]    reg_addr_q;
    logic [31:0]   reg_wdata_q, mem_addr_q, mem_wdata_q;
    logic [31:0]   reg_rdata_q, reg_rdata_d, mem_rdata_q, mem_rdata_d;
    logic          halt_q, rreq_q;
    logic [RW-1:0] rcnt_q;
    logic          to_hit;
    logic          latch;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        reg_rdata_d = reg_rdata_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            IDLE: if (start_q || pend_q) begin
                state_d = CAPT;
                pend_d  = start_q && pend_q;
            end
            CAPT: begin
                state_d     = BUS;
                reg_rdata_d = reg_rdata_i;
            end
            BUS: if (bus_gnt_i) begin
                state_d     = DONE;
                mem_rdata_d = mem_we_q ? mem_rdata_q : bus_rdata_i;
            end else if (to_hit) begin
                state_d     = DONE;
                mem_rdata_d = mem_we_q ? mem_rdata_q : 32'hDEAD_BEEF;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A start arriving mid-operation is remembered once; further ones are lost.
        if (start_q && state_q != IDLE) pend_d = 1'b1;
    end

    assign latch = state_q == IDLE && state_d == CAPT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            start_q     <= 1'b0;
            pend_q      <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            reg_rdata_q <= '0;
            mem_rdata_q <= '0;
            halt_q      <= 1'b0;
            rreq_q      <= 1'b0;
            rcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            s1_q        <= dbg_op_req_i;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            start_q     <= s2_q & ~s3_q;
            pend_q      <= pend_d;
            reg_rdata_q <= reg_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            halt_q      <= dbg_halt_req_i;
            rreq_q      <= dbg_reset_req_i;
            rcnt_q      <= (dbg_reset_req_i && !rreq_q) ? RW'(RST_CYCLES)
                         : (rcnt_q != '0) ? rcnt_q - RW'(1) : rcnt_q;
            if (latch) begin
                reg_we_q    <= dbg_reg_we_i;
                reg_addr_q  <= dbg_reg_addr_i;
                reg_wdata_q <= dbg_reg_wdata_i;
                mem_we_q    <= dbg_mem_we_i;
                mem_addr_q  <= dbg_mem_addr_i;
                mem_wdata_q <= dbg_mem_wdata_i;
            end
        end
    end

`ifdef JTAG_BRIDGE_TIMEOUT_EN
    logic [7:0] to_q;
    logic       err_q;

    // Fires in the TIMEOUT_CYCLES-th ungranted BUS cycle, so bus_req_o is held that many cycles.
    assign to_hit = state_q == BUS && !bus_gnt_i && to_q == 8'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q  <= (state_q == BUS && !bus_gnt_i && !to_hit) ? to_q + 8'd1 : 8'd0;
            err_q <= err_q | to_hit;
        end
    end

    assign err_o = err_q;
`else
    assign to_hit = 1'b0;
    assign err_o  = 1'b0;
`endif

    assign reg_we_o        = state_q == CAPT && reg_we_q;
    assign reg_addr_o      = reg_addr_q;
    assign reg_wdata_o     = reg_wdata_q;
    assign bus_req_o       = state_q == BUS;
    assign bus_we_o        = bus_req_o && mem_we_q;
    assign bus_addr_o      = mem_addr_q;
    assign bus_wdata_o     = mem_wdata_q;
    assign dbg_reg_rdata_o = reg_rdata_q;
    assign dbg_mem_rdata_o = mem_rdata_q;
    assign core_halt_o     = halt_q;
    assign core_rst_req_o  = rcnt_q != '0;
    assign busy_o          = state_q != IDLE;
endmodule

// File: doc/jtag_dbg_bridge.md
# jtag_dbg_bridge

Core-clock-domain consumer of the debug request signals produced by the JTAG top level. It resynchronises the JTAG-side `op_req` level and edge-detects it into single debug operations. Each operation becomes one register-file write strobe and one system-bus transaction, either a write or a read. The block also conditions halt and reset requests for the core.

## Interface
Parameters:
- `RST_CYCLES`, default 16: length in clk cycles of the `core_rst_req_o` pulse (≥1).
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles to wait for bus grant (8-bit counter).

Ports:
- `clk` in 1: core clock.
- `rst_n` in 1: reset; synchronous, active-low, sampled on `clk` rising edge.
- `dbg_op_req_i` in 1: operation request level from the JTAG domain (unsynchronised).
- `dbg_reg_we_i` in 1: register write enable (already 2-flop synchronised upstream).
- `dbg_reg_addr_i` in 5: register address (quasi-static while op_req is high).
- `dbg_reg_wdata_i` in 32: register write data (quasi-static).
- `dbg_mem_we_i` in 1: memory write enable (already synchronised).
- `dbg_mem_addr_i` in 32: memory address (quasi-static).
- `dbg_mem_wdata_i` in 32: memory write data (quasi-static).
- `dbg_halt_req_i` in 1: halt request (already synchronised).
- `dbg_reset_req_i` in 1: reset request (already synchronised).
- `dbg_reg_rdata_o` out 32: captured register read data, returned to the JTAG top.
- `dbg_mem_rdata_o` out 32: captured bus read data, returned to the JTAG top.
- `reg_we_o` out 1: register-file write strobe.
- `reg_addr_o` out 5: register-file read/write address.
- `reg_wdata_o` out 32: register-file write data.
- `reg_rdata_i` in 32: register-file read data (combinational).
- `bus_req_o` out 1: bus request.
- `bus_we_o` out 1: bus write.
- `bus_addr_o` out 32: bus address.
- `bus_wdata_o` out 32: bus write data.
- `bus_gnt_i` in 1: grant; a transfer completes in the cycle where `bus_req_o && bus_gnt_i`.
- `bus_rdata_i` in 32: read data, valid in the completion cycle.
- `core_halt_o` out 1: registered halt to the core.
- `core_rst_req_o` out 1: stretched reset pulse.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `err_o` out 1: sticky bus-timeout flag.

## Operation
- `dbg_op_req_i` passes through a 2-flop synchroniser (s1, s2) plus a delay flop s3. A start event is `s2 & ~s3`.
- FSM states are IDLE, CAPT, BUS, DONE.
  - IDLE, on start → CAPT. Latch the reg address/data/we and the mem address/data/we into holding registers.
  - CAPT, 1 cycle:
    - `reg_we_o` = latched reg_we for exactly this cycle.
    - `dbg_reg_rdata_o` <= `reg_rdata_i` (reads the latched address).
    - → BUS.
  - BUS:
    - `bus_req_o` = 1, with `bus_we_o`, address and data taken from the latches.
    - On grant → DONE. If the latched mem_we is 0, `dbg_mem_rdata_o` <= `bus_rdata_i`. For writes, `dbg_mem_rdata_o` is unchanged.
  - DONE, 1 cycle → IDLE.
- `reg_addr_o` and `reg_wdata_o` always drive the latched values.
- A start event while not in IDLE sets a 1-deep pending flag. IDLE with pending set enters CAPT next cycle and clears the flag. A second overlapping start is dropped.
- `core_halt_o` = registered `dbg_halt_req_i` (1-cycle delay).
- On a rising edge of `dbg_reset_req_i`, `core_rst_req_o` is high for exactly `RST_CYCLES` cycles.
  - A new rising edge during the pulse restarts the count.
  - The FSM is unaffected, so an in-flight bus transaction completes.
- Reset values:
  - All outputs 0: both rdata registers, `reg_we_o`, `bus_req_o`, `bus_we_o`, address and data outputs, `core_halt_o`, `core_rst_req_o`, `busy_o`, `err_o`.
  - Internal: FSM = IDLE, s1/s2/s3 = 0, pending = 0, counters = 0.
- Reset asserted mid-operation aborts immediately. No completion and no rdata update occur.

## Timing
- Let `dbg_op_req_i` first be sampled high at edge N.
  - Start is detected after edge N+2.
  - CAPT (`reg_we_o` high) occupies the cycle after edge N+3.
  - `bus_req_o` is first high after edge N+4.
- With grant in the first BUS cycle, `busy_o` is high for 3 cycles.
- `bus_req_o` stays asserted and its payload stays stable until grant; they never change while waiting.
- `dbg_mem_rdata_o` updates on the edge closing the completion cycle.

## Configuration
- `JTAG_BRIDGE_TIMEOUT_EN` defined:
  - An 8-bit counter increments each BUS cycle without grant.
  - When it reaches `TIMEOUT_CYCLES`, `bus_req_o` drops, the FSM → DONE, `err_o` is set (sticky until `rst_n`), and `dbg_mem_rdata_o` <= 32'hDEAD_BEEF (read ops only).
- Undefined: no counter exists; BUS waits indefinitely; `err_o` is tied to 0.

## Test plan
- After reset, all outputs are 0. Raise `dbg_op_req_i` with reg_we=1, addr=5'd3, wdata=32'h1234_5678, mem_we=0, mem_addr=32'h1000_0000; `bus_gnt_i`=1 and `bus_rdata_i`=32'hCAFE_0001. Required:
  - A single-cycle `reg_we_o` to x3 with 32'h1234_5678.
  - One read with `bus_we_o`=0.
  - `dbg_mem_rdata_o`=32'hCAFE_0001.
  - `busy_o` high for 3 cycles.
- Memory write of 32'hA5A5_A5A5 to 32'h2000_0004, with grant held low for 5 cycles. Required:
  - `bus_req_o` and its payload stay stable for 6 cycles.
  - `dbg_mem_rdata_o` is unchanged.
- Second `dbg_op_req_i` rising edge while in BUS → executes immediately after DONE. A third edge in the same window → dropped (exactly two `reg_we_o` pulses).
- `dbg_reset_req_i` rises with `RST_CYCLES`=4 → `core_rst_req_o` high for exactly 4 cycles. Re-raising it after 2 cycles → 6 cycles high in total.
- With `JTAG_BRIDGE_TIMEOUT_EN`, `TIMEOUT_CYCLES`=10, and grant never asserted, a read → `bus_req_o` drops after 10 cycles, `err_o`=1, `dbg_mem_rdata_o`=32'hDEAD_BEEF.
- `rst_n` low during BUS → next cycle IDLE, `bus_req_o`=0, `busy_o`=0, and `dbg_mem_rdata_o` keeps its reset value 0.
